// File: rtl/pm_load_ctrl.sv
// Byte-serial program-memory loader: packs pad bytes little-endian into words and holds the CPU in reset until run.
// Optional build macro PM_LOAD_AUTOINC_EN: word address comes from an internal counter instead of addr_in.
module pm_load_ctrl #(
    parameter int DATAWIDTH = 32,
    parameter int ADDWIDTH  = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           byte_in,
    input  logic                 wr_en_in,
    input  logic [ADDWIDTH-1:0]  addr_in,
    input  logic                 run_in,
    output logic                 pm_we,
    output logic [ADDWIDTH-1:0]  pm_waddr,
    output logic [DATAWIDTH-1:0] pm_wdata,
    output logic                 cpu_rst,
    output logic                 busy,
    output logic [ADDWIDTH-1:0]  word_cnt
);

    localparam int NBYTES = DATAWIDTH / 8;
    localparam int IDXW   = $clog2(NBYTES + 1);

    typedef enum logic [1:0] {IDLE, COLLECT, COMMIT, RUN} state_t;

    state_t               state_reg, state_next;
    logic [2:0]           wr_sync_reg;
    logic [1:0]           run_sync_reg;
    logic [IDXW-1:0]      idx_reg;
    logic [7:0]           buf_reg [NBYTES];
    logic [DATAWIDTH-1:0] buf_word;
    logic [ADDWIDTH-1:0]  addr_reg;
    logic [ADDWIDTH-1:0]  waddr_reg;
    logic [DATAWIDTH-1:0] wdata_reg;
    logic [ADDWIDTH-1:0]  cnt_reg;
    logic [ADDWIDTH-1:0]  word_addr;
    logic                 strobe;
    logic                 run_sync;
    logic                 capture;
    logic                 full;
    logic                 leave_run;

    // Bit 2 is only the previous synchronized level, used for edge detection.
    assign strobe    = wr_sync_reg[1] & ~wr_sync_reg[2];
    assign run_sync  = run_sync_reg[1];
    assign full      = (idx_reg == IDXW'(NBYTES));
    assign capture   = strobe && ((state_reg == IDLE) || (state_reg == COLLECT && !full));
    assign leave_run = (state_reg == RUN) && !run_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_sync_reg  <= '0;
            run_sync_reg <= '0;
        end else begin
            wr_sync_reg  <= {wr_sync_reg[1:0], wr_en_in};
            run_sync_reg <= {run_sync_reg[0], run_in};
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (strobe)        state_next = COLLECT;
                else if (run_sync) state_next = RUN;
            end
            COLLECT: if (full)      state_next = COMMIT;
            COMMIT:                 state_next = IDLE;
            RUN:     if (!run_sync) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   idx_reg <= '0;
        else if (state_reg == COMMIT) idx_reg <= '0;
        else if (capture)             idx_reg <= idx_reg + 1'b1;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_byte
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    buf_reg[gi] <= '0;
                else if (capture && idx_reg == IDXW'(gi))
                    buf_reg[gi] <= byte_in;
            end
            assign buf_word[gi*8 +: 8] = buf_reg[gi];
        end
    endgenerate

`ifdef PM_LOAD_AUTOINC_EN
    logic [ADDWIDTH-1:0] ainc_reg;
    logic                addr_in_unused;

    assign addr_in_unused = ^addr_in;
    assign word_addr      = ainc_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   ainc_reg <= '0;
        else if (leave_run)           ainc_reg <= '0;
        else if (state_reg == COMMIT) ainc_reg <= ainc_reg + 1'b1;
    end
`else
    assign word_addr = addr_in;
`endif

    // Address is frozen at the byte-0 strobe so later pad changes cannot alter this word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            addr_reg <= '0;
        else if (strobe && state_reg == IDLE)  addr_reg <= word_addr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waddr_reg <= '0;
            wdata_reg <= '0;
        end else if (state_reg == COLLECT && full) begin
            waddr_reg <= addr_reg;
            wdata_reg <= buf_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   cnt_reg <= '0;
        else if (leave_run)           cnt_reg <= '0;
        else if (state_reg == COMMIT) cnt_reg <= cnt_reg + 1'b1;
    end

    assign pm_we    = (state_reg == COMMIT);
    assign pm_waddr = waddr_reg;
    assign pm_wdata = wdata_reg;
    assign cpu_rst  = (state_reg != RUN);
    assign busy     = (state_reg == COLLECT) || (state_reg == COMMIT);
    assign word_cnt = cnt_reg;

endmodule

// File: tb/tb_pm_load_ctrl.sv
// Directed bench for pm_load_ctrl: byte loading, strobe timing, run handshake, reset abort and counter wrap.
module tb_pm_load_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  byte_in;
    logic        wr_en_in;
    logic [6:0]  addr_in;
    logic        run_in;
    logic        pm_we;
    logic [6:0]  pm_waddr;
    logic [31:0] pm_wdata;
    logic        cpu_rst;
    logic        busy;
    logic [6:0]  word_cnt;

    int vecs = 0;
    int errs = 0;
    int pulses = 0;
    logic [6:0]  mon_addr = '0;
    logic [31:0] mon_data = '0;
    logic [6:0]  exp_ainc = '0;
    logic [6:0]  exp_cnt  = '0;

    pm_load_ctrl #(.DATAWIDTH(32), .ADDWIDTH(7)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .byte_in  (byte_in),
        .wr_en_in (wr_en_in),
        .addr_in  (addr_in),
        .run_in   (run_in),
        .pm_we    (pm_we),
        .pm_waddr (pm_waddr),
        .pm_wdata (pm_wdata),
        .cpu_rst  (cpu_rst),
        .busy     (busy),
        .word_cnt (word_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pm_we === 1'b1) begin
            pulses++;
            mon_addr = pm_waddr;
            mon_data = pm_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Raise wr_en_in just before edge k and hold it over three edges; pm_we is expected only
    // at the 4th negedge, i.e. between t+1 and t+2 where t=k+2 is the last-byte capture edge.
    task automatic send_byte(input logic [7:0] b, input bit last, input bit chk_busy);
        @(negedge clk);
        byte_in  = b;
        wr_en_in = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 3) wr_en_in = 1'b0;
            check("pm_we_timing", {31'd0, pm_we}, {31'd0, (last && i == 4)});
            if (chk_busy && i == 2) check("busy_before_capture", {31'd0, busy}, 32'd0);
            if (chk_busy && i == 3) check("busy_after_capture", {31'd0, busy}, 32'd1);
        end
    endtask

    function automatic logic [6:0] exp_addr(input logic [6:0] a);
`ifdef PM_LOAD_AUTOINC_EN
        return exp_ainc;
`else
        return a;
`endif
    endfunction

    task automatic load_word(input logic [31:0] w, input logic [6:0] a, input logic [6:0] a_after);
        int p0;
        p0 = pulses;
        addr_in = a;
        for (int b = 0; b < 4; b++) begin
            send_byte(w[8*b +: 8], b == 3, b == 0);
            if (b == 0) addr_in = a_after;
        end
        check("pulse_count", pulses - p0, 32'd1);
        check("pm_waddr", {25'd0, mon_addr}, {25'd0, exp_addr(a)});
        check("pm_wdata", mon_data, w);
        exp_ainc = exp_ainc + 7'd1;
        exp_cnt  = exp_cnt + 7'd1;
        check("word_cnt", {25'd0, word_cnt}, {25'd0, exp_cnt});
    endtask

    initial begin
        rst_n = 1'b0; byte_in = '0; wr_en_in = 1'b0; addr_in = '0; run_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pm_we",    {31'd0, pm_we},      32'd0);
        check("rst_pm_waddr", {25'd0, pm_waddr},   32'd0);
        check("rst_pm_wdata", pm_wdata,            32'd0);
        check("rst_cpu_rst",  {31'd0, cpu_rst},    32'd1);
        check("rst_busy",     {31'd0, busy},       32'd0);
        check("rst_word_cnt", {25'd0, word_cnt},   32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic word and address latching against later addr_in changes
        load_word(32'h0010_0513, 7'h05, 7'h05);
        check("cpu_rst_load", {31'd0, cpu_rst}, 32'd1);
        check("busy_idle",    {31'd0, busy},    32'd0);
        check("wdata_hold",   pm_wdata,         32'h0010_0513);
        load_word(32'hDDCC_BBAA, 7'h22, 7'h7F);

        // run_in raised mid-word is ignored until the word is committed
        addr_in = 7'h10;
        send_byte(8'h01, 1'b0, 1'b1);
        send_byte(8'h02, 1'b0, 1'b0);
        run_in = 1'b1;
        repeat (4) @(negedge clk);
        check("collect_busy",    {31'd0, busy},    32'd1);
        check("collect_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        send_byte(8'h03, 1'b0, 1'b0);
        send_byte(8'h04, 1'b1, 1'b0);
        check("run_pm_waddr", {25'd0, mon_addr}, {25'd0, exp_addr(7'h10)});
        check("run_pm_wdata", mon_data, 32'h0403_0201);
        exp_ainc = exp_ainc + 7'd1;
        exp_cnt  = exp_cnt + 7'd1;
        check("run_word_cnt", {25'd0, word_cnt}, {25'd0, exp_cnt});
        check("run_cpu_rst",  {31'd0, cpu_rst},  32'd0);
        check("pulses_3",     pulses,            32'd3);

        // Strobes in RUN are dropped
        for (int i = 0; i < 4; i++) send_byte(8'hE0 + 8'(i), 1'b0, 1'b0);
        check("run_no_we",    pulses,           32'd3);
        check("run_busy",     {31'd0, busy},    32'd0);
        check("run_cpu_rst2", {31'd0, cpu_rst}, 32'd0);
        run_in = 1'b0;
        repeat (4) @(negedge clk);
        exp_ainc = '0;
        exp_cnt  = '0;
        check("exit_cpu_rst",  {31'd0, cpu_rst},  32'd1);
        check("exit_word_cnt", {25'd0, word_cnt}, 32'd0);

        // Reset in the middle of a word discards it
        addr_in = 7'h33;
        send_byte(8'h11, 1'b0, 1'b1);
        send_byte(8'h22, 1'b0, 1'b0);
        send_byte(8'h33, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_busy",  {31'd0, busy}, 32'd0);
        check("midrst_wdata", pm_wdata,      32'd0);
        rst_n = 1'b1;
        exp_ainc = '0;
        exp_cnt  = '0;
        repeat (2) @(negedge clk);
        check("midrst_no_we", pulses, 32'd3);
        load_word(32'hF0DE_BC9A, 7'h44, 7'h44);
        check("midrst_pulses", pulses, 32'd4);

        // Fill to 128 committed words, then one more to show word_cnt wrap
        for (int i = 1; i < 128; i++)
            load_word({8'(i), 8'(i ^ 8'h5A), 8'(~i), 8'(i)}, 7'(i), 7'(i));
        check("wrap_zero", {25'd0, word_cnt}, 32'd0);
        load_word(32'h1234_5678, 7'h00, 7'h00);
        check("wrap_one",  {25'd0, word_cnt}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
